mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle CPU main controller: a Moore state machine that sequences instruction fetch, decode, execute, memory and write-back over several cycles. It drives every datapath select and write strobe, including the 2-bit register-destination select of the 5-bit 4:1 write-address mux. Variable-latency memory is supported through a ready handshake. The block sits beside the datapath and takes opcode/funct from the instruction register and `zero` from the ALU.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `pc_wr` out 1: PC load enable, branch condition already resolved.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `ir_wr` out 1: IR load.
- `reg_dst` out 2: write-address mux select: 00=rt, 01=rd, 10=$31, 11 never driven.
- `mem_to_reg` out 2: write data select: 00=ALUOut, 01=MDR, 10=PC.
- `reg_wr` out 1: register file write.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `alu_ctrl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt, 100 nor.
- `pc_src` out 2: 00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr).
- `state` out 4: current state, for debug.

## Operation
- States: IF(0), ID(1), MADR(2), MRD(3), LWB(4), MWR(5), REX(6), RWB(7), BR(8), JMP(9), IEX(10), IWB(11), JAL(12), JR(13).
- IF: mem_rd=1, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - Holds until `mem_ready`.
  - In the ready cycle: ir_wr=1 and pc_wr=1, then go to ID.
- ID: alu_src_b=11, add (branch target into ALUOut).
- Dispatch from ID:
  - lw/sw → MADR.
  - R-type → REX, except funct 001000 → JR.
  - beq/bne → BR.
  - addi/andi/ori/slti → IEX.
  - j → JMP; jal → JAL.
  - Any other opcode → IF (illegal; no architectural write).
- MADR: A+imm. Then lw → MRD, sw → MWR.
- MRD: mem_rd=1, iord=1. Holds until `mem_ready`, then → LWB.
- LWB: reg_dst=00, mem_to_reg=01, reg_wr=1. Then → IF.
- MWR: mem_wr=1, iord=1. Holds until `mem_ready`, then → IF.
- REX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 100000 → add; 100010 → sub; 100100 → and; 100101 → or; 101010 → slt; 100111 → nor.
  - Any other funct → add.
- RWB: reg_dst=01, reg_wr=1. Then → IF.
- BR: sub, pc_src=01, pc_wr = zero XOR is_bne. Then → IF.
- IEX: alu_src_a=1, alu_src_b=10, op from opcode (addi add, andi and, ori or, slti slt). IWB: reg_dst=00, reg_wr=1. Then → IF.
- JMP: pc_src=10, pc_wr=1. Then → IF.
- JAL: reg_dst=10, mem_to_reg=10, reg_wr=1, pc_src=10, pc_wr=1. Then → IF.
- JR: pc_src=11, pc_wr=1. Then → IF.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from the state register, plus `mem_ready`/`zero` where noted. No output depends on opcode except in REX, IEX and BR.
- Reset: state=IF immediately and asynchronously; internal run flag=0.
- While run=0, every strobe is forced to 0 (pc_wr, ir_wr, mem_rd, mem_wr, reg_wr) and all selects are 0.
- run sets on the first rising edge after rst_n deasserts, so the first fetch request appears in cycle 1 after release.
- Latency with zero-wait memory (mem_ready in the first cycle):
  - R/I-type, beq/bne, j/jal/jr: 4, 3, 3 cycles; lw 5; sw 4.
  - Each extra wait cycle adds 1.
- `mem_ready` is ignored outside IF, MRD and MWR.
- Reset mid-instruction aborts without a write. A reset asserted in the same cycle as a RWB/LWB write suppresses reg_wr.

## Configuration
- `MC_CTRL_JAL_EN` defined: JAL and JR states exist; reg_dst=10 and pc_src=11 are reachable.
- Not defined: jal and jr decode as illegal (ID→IF). reg_dst never exceeds 01, mem_to_reg never 10, pc_src never 11.

## Structure
- Shared package `mc_pkg`: state enum (4-bit codes above), opcode/funct constants, alu_ctrl encodings, reg_dst/mem_to_reg/pc_src/alu_src_b select encodings.
- One sub-module `mc_alu_dec`: combinational (state, opcode, funct) → alu_ctrl.

## Test plan
- Reset held 3 cycles with mem_ready=1: all strobes 0. Release: mem_rd=1 in cycle 1, ir_wr=pc_wr=1 the same cycle, state=ID next.
- add (opcode 000000, funct 100000), zero-wait memory: state sequence IF,ID,REX,RWB,IF; in RWB reg_dst=01, reg_wr=1.
- lw with mem_ready low 2 cycles in MRD: state holds MRD for 3 cycles; LWB shows mem_to_reg=01, reg_dst=00; total 7 cycles.
- beq with zero=1 → pc_wr=1, pc_src=01 in BR. bne with zero=1 → pc_wr=0.
- jal (opcode 000011) with MC_CTRL_JAL_EN: in JAL, reg_dst=10, mem_to_reg=10, reg_wr=1, pc_wr=1. Without the macro: ID→IF and no reg_wr.
- Illegal opcode 111111: ID→IF, no write strobe asserted at any point.

Source files
------------

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multi-cycle CPU main controller.
//   state_t       : controller state encoding (4-bit, also exported for debug)
//   OP_* / FN_*   : instruction opcode and R-type funct field values
//   ALU_*         : alu_ctrl encodings driven to the datapath ALU
//   REG_DST_*, M2R_*, PC_SRC_*, SRC_B_* : datapath mux select encodings
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,  S_ID  = 4'd1,  S_MADR = 4'd2,  S_MRD = 4'd3,
    S_LWB  = 4'd4,  S_MWR = 4'd5,  S_REX  = 4'd6,  S_RWB = 4'd7,
    S_BR   = 4'd8,  S_JMP = 4'd9,  S_IEX  = 4'd10, S_IWB = 4'd11,
    S_JAL  = 4'd12, S_JR  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_A      = 2'b11;

  localparam logic [1:0] SRC_B_B      = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if -- controller <-> datapath signal bundle.
//   master : the controller (consumes opcode/funct/zero/mem_ready, drives
//            every select, strobe and the debug state)
//   slave  : the datapath/memory side (mirror image)
// -----------------------------------------------------------------------------
interface mc_ctrl_if;
  import mc_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_wr;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_wr;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  state_t     state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_wr, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
           alu_src_a, alu_src_b, alu_ctrl, pc_src, state
  );
endinterface

// File: rtl/mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mc_alu_dec -- combinational ALU operation decode.
//   state    in  4 : current controller state
//   opcode   in  6 : IR[31:26], selects the op in IEX
//   funct    in  6 : IR[5:0],   selects the op in REX
//   alu_ctrl out 3 : ALU operation; 000 in states that do not use the ALU
// -----------------------------------------------------------------------------
module mc_alu_dec
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (state)
      S_IF, S_ID, S_MADR: alu_ctrl = ALU_ADD;
      S_BR:               alu_ctrl = ALU_SUB;
      S_REX: begin
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_NOR:  alu_ctrl = ALU_NOR;
          default: alu_ctrl = ALU_ADD;   // includes FN_ADD and unknown functs
        endcase
      end
      S_IEX: begin
        case (opcode)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;   // addi
        endcase
      end
      default: alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm -- multi-cycle CPU main controller (Moore FSM).
// Sequences IF / ID / execute / memory / write-back and drives every datapath
// select and write strobe. Memory latency is absorbed by holding IF, MRD and
// MWR until mem_ready.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : mc_ctrl_if.master (opcode/funct/zero/mem_ready in; pc_wr,
//                iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
//                alu_src_a, alu_src_b, alu_ctrl, pc_src, state out)
// Build option: define MC_CTRL_JAL_EN to add the JAL and JR states; without it
// jal and jr decode as illegal and return to IF without any write.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mc_ctrl_if.master    bus
);

  state_t     state_q, state_d;
  logic       run_q;       // low for the first cycle after reset release
  logic [2:0] alu_dec;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the async reset also kills all strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  mc_alu_dec u_alu_dec (
    .state    (state_q),
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .alu_ctrl (alu_dec)
  );

  assign bus.state    = state_q;
  assign bus.alu_ctrl = run_q ? alu_dec : ALU_AND;

  always_comb begin
    // NOTE: every output and the next state get a default first, so a state
    // that leaves one unassigned cannot infer a latch.
    state_d        = state_q;
    bus.pc_wr      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.ir_wr      = 1'b0;
    bus.reg_dst    = REG_DST_RT;
    bus.mem_to_reg = M2R_ALUOUT;
    bus.reg_wr     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRC_B_B;
    bus.pc_src     = PC_SRC_ALU;

    if (!run_q) begin
      state_d = S_IF;
    end else begin
      case (state_q)
        S_IF: begin
          bus.mem_rd    = 1'b1;
          bus.alu_src_b = SRC_B_FOUR;
          if (bus.mem_ready) begin
            bus.ir_wr = 1'b1;
            bus.pc_wr = 1'b1;
            state_d   = S_ID;
          end
        end
        S_ID: begin
          bus.alu_src_b = SRC_B_IMM_SH;   // branch target into ALUOut
          case (bus.opcode)
            OP_LW, OP_SW:                     state_d = S_MADR;
`ifdef MC_CTRL_JAL_EN
            OP_RTYPE: state_d = (bus.funct == FN_JR) ? S_JR : S_REX;
            OP_JAL:                           state_d = S_JAL;
`else
            OP_RTYPE: state_d = (bus.funct == FN_JR) ? S_IF : S_REX;
`endif
            OP_BEQ, OP_BNE:                   state_d = S_BR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEX;
            OP_J:                             state_d = S_JMP;
            default:                          state_d = S_IF;
          endcase
        end
        S_MADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRC_B_IMM;
          state_d       = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
        end
        S_MRD: begin
          bus.mem_rd = 1'b1;
          bus.iord   = 1'b1;
          if (bus.mem_ready) state_d = S_LWB;
        end
        S_LWB: begin
          bus.reg_dst    = REG_DST_RT;
          bus.mem_to_reg = M2R_MDR;
          bus.reg_wr     = 1'b1;
          state_d        = S_IF;
        end
        S_MWR: begin
          bus.mem_wr = 1'b1;
          bus.iord   = 1'b1;
          if (bus.mem_ready) state_d = S_IF;
        end
        S_REX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRC_B_B;
          state_d       = S_RWB;
        end
        S_RWB: begin
          bus.reg_dst = REG_DST_RD;
          bus.reg_wr  = 1'b1;
          state_d     = S_IF;
        end
        S_BR: begin
          bus.pc_src = PC_SRC_ALUOUT;
          bus.pc_wr  = bus.zero ^ (bus.opcode == OP_BNE);
          state_d    = S_IF;
        end
        S_IEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRC_B_IMM;
          state_d       = S_IWB;
        end
        S_IWB: begin
          bus.reg_dst = REG_DST_RT;
          bus.reg_wr  = 1'b1;
          state_d     = S_IF;
        end
        S_JMP: begin
          bus.pc_src = PC_SRC_JUMP;
          bus.pc_wr  = 1'b1;
          state_d    = S_IF;
        end
`ifdef MC_CTRL_JAL_EN
        S_JAL: begin
          bus.reg_dst    = REG_DST_RA;
          bus.mem_to_reg = M2R_PC;
          bus.reg_wr     = 1'b1;
          bus.pc_src     = PC_SRC_JUMP;
          bus.pc_wr      = 1'b1;
          state_d        = S_IF;
        end
        S_JR: begin
          bus.pc_src = PC_SRC_A;
          bus.pc_wr  = 1'b1;
          state_d    = S_IF;
        end
`endif
        default: state_d = S_IF;   // unused codes recover to fetch
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm -- self-checking bench for mc_ctrl_fsm.
// A table of instruction records (opcode, funct, zero, wait counts, expected
// state path) is replayed cycle by cycle; each cycle the expected output
// bundle is pushed to a scoreboard queue and popped against the DUT at the
// falling edge. Hand-written sequences cover reset and mid-instruction aborts.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_wr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic [3:0] state;
  } out_t;

  typedef struct packed {
    logic [5:0]      op;
    logic [5:0]      fn;
    logic            z;
    logic [1:0]      wait_if;
    logic [1:0]      wait_mem;
    logic [2:0]      len;
    logic [4:0][3:0] path;
  } vec_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  out_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input out_t act, input out_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got state=%0d bundle=%h, expected state=%0d bundle=%h",
               name, act.state, act, exp.state, exp);
    end
  endtask

  function automatic out_t snap();
    out_t o;
    o.pc_wr      = bus.pc_wr;
    o.iord       = bus.iord;
    o.mem_rd     = bus.mem_rd;
    o.mem_wr     = bus.mem_wr;
    o.ir_wr      = bus.ir_wr;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_wr     = bus.reg_wr;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_ctrl   = bus.alu_ctrl;
    o.pc_src     = bus.pc_src;
    o.state      = bus.state;
    return o;
  endfunction

  // Per-state output table written from the controller description.
  function automatic out_t exp_out(input state_t st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z,
                                   input logic rdy);
    out_t o = '0;
    o.state = st;
    case (st)
      S_IF: begin
        o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
        o.ir_wr = rdy; o.pc_wr = rdy;
      end
      S_ID:   begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
      S_MADR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
      S_MRD:  begin o.mem_rd = 1'b1; o.iord = 1'b1; end
      S_LWB:  begin o.mem_to_reg = 2'b01; o.reg_wr = 1'b1; end
      S_MWR:  begin o.mem_wr = 1'b1; o.iord = 1'b1; end
      S_REX: begin
        o.alu_src_a = 1'b1;
        case (fn)
          6'b100010: o.alu_ctrl = 3'b110;
          6'b100100: o.alu_ctrl = 3'b000;
          6'b100101: o.alu_ctrl = 3'b001;
          6'b101010: o.alu_ctrl = 3'b111;
          6'b100111: o.alu_ctrl = 3'b100;
          default:   o.alu_ctrl = 3'b010;
        endcase
      end
      S_RWB: begin o.reg_dst = 2'b01; o.reg_wr = 1'b1; end
      S_BR: begin
        o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
        o.pc_wr = z ^ (op == 6'b000101);
      end
      S_IEX: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        case (op)
          6'b001100: o.alu_ctrl = 3'b000;
          6'b001101: o.alu_ctrl = 3'b001;
          6'b001010: o.alu_ctrl = 3'b111;
          default:   o.alu_ctrl = 3'b010;
        endcase
      end
      S_IWB: o.reg_wr = 1'b1;
      S_JMP: begin o.pc_src = 2'b10; o.pc_wr = 1'b1; end
      S_JAL: begin
        o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_wr = 1'b1;
        o.pc_src = 2'b10; o.pc_wr = 1'b1;
      end
      S_JR:  begin o.pc_src = 2'b11; o.pc_wr = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int wi, input int wm,
                              input int len, input state_t s0, input state_t s1,
                              input state_t s2, input state_t s3,
                              input state_t s4);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z;
    v.wait_if = 2'(wi); v.wait_mem = 2'(wm); v.len = 3'(len);
    v.path[0] = s0; v.path[1] = s1; v.path[2] = s2;
    v.path[3] = s3; v.path[4] = s4;
    return v;
  endfunction

  // One clock cycle: drive inputs, record expectation, compare at negedge.
  task automatic step(input string name, input state_t st, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic rdy);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = rdy;
    sb_q.push_back(exp_out(st, op, fn, z, rdy));
    @(negedge clk);
    check(name, snap(), sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Replay one instruction record, expanding the wait cycles.
  task automatic run_vec(input string name, input vec_t v);
    for (int p = 0; p < int'(v.len); p++) begin
      state_t st;
      int     n;
      st = state_t'(v.path[p]);
      n  = (st == S_IF) ? int'(v.wait_if) :
           (st == S_MRD || st == S_MWR) ? int'(v.wait_mem) : 0;
      for (int w = 0; w <= n; w++) begin
        logic rdy;
        if (st == S_IF || st == S_MRD || st == S_MWR) rdy = (w == n);
        else rdy = 1'($urandom_range(0, 1));   // must be ignored here
        step(name, st, v.op, v.fn, v.z, rdy);
      end
    end
  endtask

  // Assert reset mid-cycle, check the immediate abort, then release and check
  // the idle cycle before fetching resumes.
  task automatic abort_here(input string name);
    #1 rst_n = 1'b0;
    #1;
    sb_q.push_back('0);
    check({name, "_abort"}, snap(), sb_q.pop_front());
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.push_back('0);
    @(negedge clk);
    check({name, "_run0"}, snap(), sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back(mk(6'b000000, 6'b100000, 0, 0, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b100010, 0, 2, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b100100, 0, 0, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b100101, 1, 1, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b101010, 1, 0, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b100111, 0, 0, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b000000, 6'b000011, 0, 0, 0, 4, S_IF, S_ID, S_REX, S_RWB, S_IF));
    vecs.push_back(mk(6'b100011, 6'b000000, 0, 0, 2, 5, S_IF, S_ID, S_MADR, S_MRD, S_LWB));
    vecs.push_back(mk(6'b100011, 6'b010101, 0, 1, 0, 5, S_IF, S_ID, S_MADR, S_MRD, S_LWB));
    vecs.push_back(mk(6'b101011, 6'b000000, 0, 0, 1, 4, S_IF, S_ID, S_MADR, S_MWR, S_IF));
    vecs.push_back(mk(6'b101011, 6'b000000, 1, 0, 0, 4, S_IF, S_ID, S_MADR, S_MWR, S_IF));
    vecs.push_back(mk(6'b000100, 6'b000000, 1, 0, 0, 3, S_IF, S_ID, S_BR, S_IF, S_IF));
    vecs.push_back(mk(6'b000100, 6'b000000, 0, 0, 0, 3, S_IF, S_ID, S_BR, S_IF, S_IF));
    vecs.push_back(mk(6'b000101, 6'b000000, 1, 0, 0, 3, S_IF, S_ID, S_BR, S_IF, S_IF));
    vecs.push_back(mk(6'b000101, 6'b000000, 0, 0, 0, 3, S_IF, S_ID, S_BR, S_IF, S_IF));
    vecs.push_back(mk(6'b001000, 6'b000000, 0, 0, 0, 4, S_IF, S_ID, S_IEX, S_IWB, S_IF));
    vecs.push_back(mk(6'b001100, 6'b000000, 0, 0, 0, 4, S_IF, S_ID, S_IEX, S_IWB, S_IF));
    vecs.push_back(mk(6'b001101, 6'b000000, 0, 0, 0, 4, S_IF, S_ID, S_IEX, S_IWB, S_IF));
    vecs.push_back(mk(6'b001010, 6'b000000, 0, 0, 0, 4, S_IF, S_ID, S_IEX, S_IWB, S_IF));
    vecs.push_back(mk(6'b000010, 6'b000000, 0, 0, 0, 3, S_IF, S_ID, S_JMP, S_IF, S_IF));
`ifdef MC_CTRL_JAL_EN
    vecs.push_back(mk(6'b000011, 6'b000000, 0, 0, 0, 3, S_IF, S_ID, S_JAL, S_IF, S_IF));
    vecs.push_back(mk(6'b000000, 6'b001000, 0, 0, 0, 3, S_IF, S_ID, S_JR, S_IF, S_IF));
`else
    vecs.push_back(mk(6'b000011, 6'b000000, 0, 0, 0, 2, S_IF, S_ID, S_IF, S_IF, S_IF));
    vecs.push_back(mk(6'b000000, 6'b001000, 0, 0, 0, 2, S_IF, S_ID, S_IF, S_IF, S_IF));
`endif
    vecs.push_back(mk(6'b111111, 6'b111111, 1, 0, 0, 2, S_IF, S_ID, S_IF, S_IF, S_IF));

    bus.opcode    = 6'b100011;
    bus.funct     = 6'b000000;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held three cycles with mem_ready high: nothing may be requested.
    for (int c = 0; c < 3; c++) begin
      sb_q.push_back('0);
      @(negedge clk);
      check("reset_hold", snap(), sb_q.pop_front());
      @(posedge clk);
      #1;
    end

    // First cycle after release: run flag still low.
    rst_n = 1'b1;
    sb_q.push_back('0);
    @(negedge clk);
    check("release_cycle0", snap(), sb_q.pop_front());
    @(posedge clk);
    #1;

    // Vector table (first entry is the fetch in cycle 1 after release).
    for (int i = 0; i < vecs.size(); i++)
      run_vec($sformatf("vec%0d_op%b_fn%b", i, vecs[i].op, vecs[i].fn), vecs[i]);

    // Reset asserted during the RWB write cycle suppresses reg_wr.
    step("rwb_pre", S_IF,  6'b000000, 6'b100000, 0, 1'b1);
    step("rwb_pre", S_ID,  6'b000000, 6'b100000, 0, 1'b0);
    step("rwb_pre", S_REX, 6'b000000, 6'b100000, 0, 1'b0);
    bus.mem_ready = 1'b0;
    sb_q.push_back(exp_out(S_RWB, 6'b000000, 6'b100000, 0, 1'b0));
    @(negedge clk);
    check("rwb_write", snap(), sb_q.pop_front());
    abort_here("rwb");

    // Reset while lw waits in MRD: abort without reaching LWB.
    step("mrd_pre", S_IF,   6'b100011, 6'b000000, 0, 1'b1);
    step("mrd_pre", S_ID,   6'b100011, 6'b000000, 0, 1'b1);
    step("mrd_pre", S_MADR, 6'b100011, 6'b000000, 0, 1'b1);
    bus.mem_ready = 1'b0;
    sb_q.push_back(exp_out(S_MRD, 6'b100011, 6'b000000, 0, 1'b0));
    @(negedge clk);
    check("mrd_wait", snap(), sb_q.pop_front());
    abort_here("mrd");

    // Recovery: a normal instruction runs after the aborts.
    run_vec("recover_add", vecs[0]);
    sb_q.push_back(exp_out(S_IF, 6'b000000, 6'b100000, 0, 1'b0));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("final_if", snap(), sb_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
